gsim_band_encoder: RTL and testbench

- Inverse companion to the Gauss-Seidel solver. It accepts a solved 16-entry x vector in the solver's output format: 32-bit signed fixed point, 16 fractional bits.
- It computes b = A·x, where A is the banded matrix with 20 on the diagonal, -13 at ±1, +6 at ±2 and -1 at ±3.
- It streams the 16 rounded 16-bit b values back out. Use it as a residual checker, or as a pattern generator that produces solver stimulus.

---
 rtl/gsim_band_encoder.sv | 141 ++++++++++++++
 tb/tb_gsim_band_encoder.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/gsim_band_encoder.sv
`default_nettype none
// ============================================================================
// Module   : gsim_band_encoder
// Purpose  : b = A*x for the 7-band solver matrix; streams rounded, saturated b
// Revision : 1.0
// ============================================================================
module gsim_band_encoder #(
  parameter int N    = 16,
  parameter int XW   = 32,
  parameter int FRAC = 16,
  parameter int BW   = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 x_valid,
  input  logic [XW-1:0]        x_in,
  output logic                 x_ready,
  output logic                 b_valid,
  output logic signed [BW-1:0] b_out,
  output logic                 b_last,
  output logic                 b_sat
);
  localparam int IW = $clog2(N);
  localparam int AW = XW + 6;
  localparam logic [IW-1:0]        c_last_idx = IW'(N - 1);
  localparam logic signed [IW+1:0] c_n        = (IW + 2)'(N);
  localparam logic signed [AW-1:0] c_half     = AW'(64'sd1 <<< (FRAC - 1));
  localparam logic signed [AW-1:0] c_bmax     = AW'((64'sd1 <<< (BW - 1)) - 64'sd1);
  localparam logic signed [AW-1:0] c_bmin     = ~c_bmax;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    COMPUTE = 2'd1,
    DRAIN   = 2'd2
  } state_t;

  state_t               r_state, w_state_nxt;
  logic [IW-1:0]        r_index, w_index_nxt;
  logic [IW-1:0]        r_row, w_row_nxt;
  logic                 w_store, w_emit;
  logic signed [XW-1:0] r_xbuf [N];

  always_comb begin
    w_state_nxt = r_state;
    w_index_nxt = r_index;
    w_row_nxt   = r_row;
    w_store     = 1'b0;
    w_emit      = 1'b0;
    case (r_state)
      COLLECT: begin
        if (x_valid) begin
          w_store = 1'b1;
          if (r_index == c_last_idx) begin
            w_state_nxt = COMPUTE;
            w_row_nxt   = '0;
            w_index_nxt = '0;
          end else begin
            w_index_nxt = r_index + 1'b1;
          end
        end
      end
      COMPUTE: begin
        w_emit = 1'b1;
        if (r_row == c_last_idx) w_state_nxt = DRAIN;
        else                     w_row_nxt   = r_row + 1'b1;
      end
      DRAIN: begin
        w_state_nxt = COLLECT;
        w_index_nxt = '0;
      end
      default: w_state_nxt = COLLECT;
    endcase
  end

  // Data storage deliberately has no reset.
  always_ff @(posedge clk) begin
    if (w_store) r_xbuf[r_index] <= $signed(x_in);
  end

  // Tap k reads x[row + k - 3]; out-of-range neighbours contribute zero.
  logic signed [AW-1:0] w_tap [7];
  for (genvar k = 0; k < 7; k++) begin : g_tap
    localparam logic signed [IW+1:0] c_off = (IW + 2)'(k - 3);
    logic signed [IW+1:0] w_idx;
    logic signed [XW-1:0] w_x;
    assign w_idx    = $signed({2'b00, r_row}) + c_off;
    assign w_x      = r_xbuf[w_idx[IW-1:0]];
    assign w_tap[k] = (!w_idx[IW+1] && (w_idx < c_n)) ? {{(AW - XW){w_x[XW-1]}}, w_x} : '0;
  end

  logic signed [AW-1:0] w_p1, w_p2, w_p3, w_s, w_r;
  logic signed [BW-1:0] w_b;
  logic                 w_sat;

  assign w_p1 = w_tap[2] + w_tap[4];
  assign w_p2 = w_tap[1] + w_tap[5];
  assign w_p3 = w_tap[0] + w_tap[6];
  assign w_s  = (w_tap[3] <<< 4) + (w_tap[3] <<< 2)
              - ((w_p1 <<< 3) + (w_p1 <<< 2) + w_p1)
              + (w_p2 <<< 2) + (w_p2 <<< 1)
              - w_p3;
  assign w_r  = (w_s + c_half) >>> FRAC;

  always_comb begin
    w_b   = w_r[BW-1:0];
    w_sat = 1'b0;
    if (w_r > c_bmax) begin
      w_b   = c_bmax[BW-1:0];
      w_sat = 1'b1;
    end else if (w_r < c_bmin) begin
      w_b   = c_bmin[BW-1:0];
      w_sat = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= COLLECT;
      r_index <= '0;
      r_row   <= '0;
      x_ready <= 1'b1;
      b_valid <= 1'b0;
      b_out   <= '0;
      b_last  <= 1'b0;
      b_sat   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_index <= w_index_nxt;
      r_row   <= w_row_nxt;
      x_ready <= (w_state_nxt == COLLECT);
      b_valid <= w_emit;
      if (w_emit) begin
        b_out  <= w_b;
        b_sat  <= w_sat;
        b_last <= (r_row == c_last_idx);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_gsim_band_encoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_gsim_band_encoder
// Purpose  : directed self-checking bench for gsim_band_encoder
// Revision : 1.0
// ============================================================================
module tb_gsim_band_encoder;
  logic               clk     = 1'b0;
  logic               reset   = 1'b0;
  logic               x_valid = 1'b0;
  logic [31:0]        x_in    = '0;
  logic               x_ready, b_valid, b_last, b_sat;
  logic signed [15:0] b_out;

  int n_vec  = 0;
  int n_fail = 0;

  gsim_band_encoder #(.N(16), .XW(32), .FRAC(16), .BW(16)) dut (
    .clk     (clk),
    .reset   (reset),
    .x_valid (x_valid),
    .x_in    (x_in),
    .x_ready (x_ready),
    .b_valid (b_valid),
    .b_out   (b_out),
    .b_last  (b_last),
    .b_sat   (b_sat)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Caller is at a falling edge; returns at the falling edge after the last word's accept.
  task automatic send(input logic [31:0] v[16], input bit gapped);
    for (int i = 0; i < 16; i++) begin
      if (gapped) begin
        repeat (i % 3) begin
          x_valid = 1'b0;
          x_in    = 32'h5A5A5A5A;
          @(negedge clk);
        end
      end
      x_valid = 1'b1;
      x_in    = v[i];
      @(negedge clk);
    end
  endtask

  // Entered at the first falling edge after the last word was accepted.
  task automatic recv(input string name, input int e[16], input bit s[16],
                      input bit hold, input int abort_at);
    int low;
    check({name, " valid one cycle after accept"}, b_valid, 0);
    low     = (x_ready == 1'b0) ? 1 : 0;
    x_valid = hold;
    x_in    = 32'hDEADBEEF;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      check($sformatf("%s b%0d valid", name, k + 1), b_valid, 1);
      check($sformatf("%s b%0d out", name, k + 1), b_out, e[k]);
      check($sformatf("%s b%0d sat", name, k + 1), b_sat, s[k]);
      check($sformatf("%s b%0d last", name, k + 1), b_last, (k == 15));
      if (x_ready == 1'b0) low++;
      if (abort_at == k + 1) return;
    end
    x_valid = 1'b0;
    @(negedge clk);
    check({name, " valid after frame"}, b_valid, 0);
    check({name, " last held"}, b_last, 1);
    check({name, " ready after last"}, x_ready, 1);
    check({name, " ready-low cycles"}, low, 17);
  endtask

  initial begin
    logic [31:0] xv [16];
    int          e  [16];
    bit          s  [16];

    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("reset x_ready", x_ready, 1);
    check("reset b_valid", b_valid, 0);
    check("reset b_last", b_last, 0);
    check("reset b_sat", b_sat, 0);
    check("reset b_out", b_out, 0);
    reset = 1'b1;
    @(negedge clk);

    // All zeros
    xv = '{default: 32'h0};
    e  = '{default: 0};
    s  = '{default: 1'b0};
    send(xv, 1'b0);
    recv("zero", e, s, 1'b0, 0);

    // Unit impulse at x1, sent back-to-back with the previous frame
    xv[0] = 32'h00010000;
    e[0] = 20; e[1] = -13; e[2] = 6; e[3] = -1;
    send(xv, 1'b0);
    recv("impulse", e, s, 1'b0, 0);

    // All ones: edge truncation; x_valid held through COMPUTE must be dropped
    xv = '{default: 32'h00010000};
    e  = '{default: 4};
    e[0] = 12; e[1] = -1; e[2] = 5; e[13] = 5; e[14] = -1; e[15] = 12;
    send(xv, 1'b0);
    recv("ones", e, s, 1'b1, 0);

    // 1/32 impulse: round-half-up behaviour
    xv = '{default: 32'h0};
    xv[0] = 32'h00000800;
    e = '{default: 0};
    e[0] = 1;
    send(xv, 1'b0);
    recv("frac", e, s, 1'b0, 0);

    // Large impulse: saturation both ways
    xv[0] = 32'h10000000;
    e[0] = 32767; e[1] = -32768; e[2] = 24576; e[3] = -4096;
    s[0] = 1'b1; s[1] = 1'b1;
    send(xv, 1'b0);
    recv("sat", e, s, 1'b0, 0);

    // x_i = i, gapped input, x_valid held in COMPUTE, reset at the 5th output
    s = '{default: 1'b0};
    for (int i = 0; i < 16; i++) xv[i] = 32'(i + 1) << 16;
    for (int i = 3; i < 13; i++) e[i] = 4 * (i + 1);
    e[0] = 8; e[1] = 7; e[2] = 12; e[13] = 73; e[14] = -24; e[15] = 196;
    send(xv, 1'b1);
    recv("ramp", e, s, 1'b1, 5);
    #2 reset = 1'b0;
    #1;
    check("midreset b_valid", b_valid, 0);
    check("midreset x_ready", x_ready, 1);
    check("midreset b_out", b_out, 0);
    check("midreset b_last", b_last, 0);
    check("midreset b_sat", b_sat, 0);
    x_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;

    // Fresh frame after reset: x_i = -i
    for (int i = 0; i < 16; i++) begin
      xv[i] = -(32'(i + 1) << 16);
      e[i]  = -e[i];
    end
    send(xv, 1'b0);
    recv("negramp", e, s, 1'b0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
